// File: rtl/stl_tag_pkg.sv
// ---------------------------------------------------------------------------
// stl_tag_pkg
// Shared types and elaboration-time checks for the stl_tag_pool allocator.
//   tag_mode_e  : allocation policy (TAG_LOW = lowest free, TAG_RR = round-robin)
//   tag_cfg_ok  : legality of the TAG_W / TAG_NUM / RLS_N combination
// ---------------------------------------------------------------------------
package stl_tag_pkg;

   typedef enum logic {
      TAG_LOW = 1'b0,
      TAG_RR  = 1'b1
   } tag_mode_e;

   function automatic bit tag_cfg_ok(input int tag_w, input int tag_num,
                                     input int rls_n, input int mode);
      return (tag_w >= 1) && (tag_w <= 16) &&
             (tag_num >= 2) && (tag_num <= (1 << tag_w)) &&
             (rls_n >= 1) && (rls_n <= 4) &&
             ((mode == int'(TAG_LOW)) || (mode == int'(TAG_RR)));
   endfunction

endpackage

// File: rtl/stl_tag_find.sv
// ---------------------------------------------------------------------------
// stl_tag_find
// Combinational find-first-set over TAG_NUM bits starting at index 'start',
// wrapping past TAG_NUM-1 back to 0.
//   vec   : in  candidate vector (bit i set = tag i free)
//   start : in  first index to consider
//   found : out at least one bit of vec is set
//   idx   : out first set index at or after start (modulo TAG_NUM)
// ---------------------------------------------------------------------------
module stl_tag_find #(
   parameter int TAG_W   = 6,
   parameter int TAG_NUM = 2**TAG_W
) (
   input  logic [TAG_NUM-1:0] vec,
   input  logic [TAG_W-1:0]   start,
   output logic               found,
   output logic [TAG_W-1:0]   idx
);

   localparam int PW = TAG_W + 1;

   logic [2*TAG_NUM-1:0] dbl;
   logic [PW-1:0]        pos;

   // The doubled vector masked below 'start' makes the wrapped search a plain
   // lowest-set-bit search; any hit in the upper copy folds back by TAG_NUM.
   always_comb begin
      dbl = {vec, vec};
      for (int j = 0; j < 2*TAG_NUM; j++) begin
         if (j < int'(start)) dbl[j] = 1'b0;
      end
      pos = '0;
      for (int j = 2*TAG_NUM-1; j >= 0; j--) begin
         if (dbl[j]) pos = PW'(j);
      end
   end

   assign found = |vec;
   assign idx   = TAG_W'((pos >= PW'(TAG_NUM)) ? pos - PW'(TAG_NUM) : pos);

endmodule

// File: rtl/stl_tag_pool.sv
// ---------------------------------------------------------------------------
// stl_tag_pool
// Multi-release tag allocator. Keeps one pre-allocated tag in a registered
// valid/ready output and accepts up to RLS_N tag returns per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : in  synchronous flush back to the reset state
//   tag_vld    : out tag holds an allocated tag
//   tag_rdy    : in  consumer takes tag when tag_vld && tag_rdy
//   tag        : out allocated tag
//   rls_en     : in  per-port release strobe
//   rls_tag    : in  per-port released tag, port p at [p*TAG_W +: TAG_W]
//   free_cnt   : out free tags, not counting the one held in the output
//   empty      : out free_cnt == 0
//   err_rls    : out pulse, an illegal release occurred the previous cycle
// ---------------------------------------------------------------------------
module stl_tag_pool
   import stl_tag_pkg::*;
#(
   parameter int TAG_W   = 6,
   parameter int TAG_NUM = 2**TAG_W,
   parameter int RLS_N   = 2,
   parameter int MODE    = 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clr,
   output logic                   tag_vld,
   input  logic                   tag_rdy,
   output logic [TAG_W-1:0]       tag,
   input  logic [RLS_N-1:0]       rls_en,
   input  logic [RLS_N*TAG_W-1:0] rls_tag,
   output logic [TAG_W:0]         free_cnt,
   output logic                   empty,
   output logic                   err_rls
);

   if (!tag_cfg_ok(TAG_W, TAG_NUM, RLS_N, MODE)) begin : g_cfg_err
      $error("stl_tag_pool: illegal TAG_W/TAG_NUM/RLS_N/MODE combination");
   end

   logic [TAG_NUM-1:0] fv;
   logic [TAG_W-1:0]   ptr;
   logic [TAG_W-1:0]   start;
   logic [TAG_W-1:0]   f;
   logic               found;
   logic               ld;
   logic [TAG_NUM-1:0] ld_clr;
   logic [TAG_NUM-1:0] rls_set;
   logic [2:0]         rls_cnt;
   logic               rls_bad;
   logic               ok;
   logic [TAG_W-1:0]   rt [RLS_N];
   logic [TAG_W:0]     cnt_nxt;

   assign start = (MODE == int'(TAG_RR)) ? ptr : '0;

   stl_tag_find #(
      .TAG_W   (TAG_W),
      .TAG_NUM (TAG_NUM)
   ) u_find (
      .vec   (fv),
      .start (start),
      .found (found),
      .idx   (f)
   );

   assign ld = (!tag_vld || tag_rdy) && found;

   always_comb begin
      for (int i = 0; i < TAG_NUM; i++) ld_clr[i] = ld && (int'(f) == i);
   end

   // A port is dropped if the tag is out of range, already free, sitting in
   // the output register, or claimed by a lower port in the same cycle.
   always_comb begin
      rls_set = '0;
      rls_cnt = '0;
      rls_bad = 1'b0;
      ok      = 1'b0;
      for (int p = 0; p < RLS_N; p++) rt[p] = rls_tag[p*TAG_W +: TAG_W];
      for (int p = 0; p < RLS_N; p++) begin
         ok = 1'b0;
         if (rls_en[p]) begin
            ok = (int'(rt[p]) < TAG_NUM) && !(tag_vld && (rt[p] == tag));
            for (int i = 0; i < TAG_NUM; i++) begin
               if ((int'(rt[p]) == i) && fv[i]) ok = 1'b0;
            end
            for (int q = 0; q < p; q++) begin
               if (rls_en[q] && (rt[q] == rt[p])) ok = 1'b0;
            end
            if (ok) begin
               for (int i = 0; i < TAG_NUM; i++) begin
                  if (int'(rt[p]) == i) rls_set[i] = 1'b1;
               end
               rls_cnt = rls_cnt + 3'd1;
            end else begin
               rls_bad = 1'b1;
            end
         end
      end
   end

   assign cnt_nxt = free_cnt + (TAG_W+1)'(rls_cnt) - (TAG_W+1)'(ld);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fv       <= '1;
         tag_vld  <= 1'b0;
         tag      <= '0;
         ptr      <= '0;
         free_cnt <= (TAG_W+1)'(TAG_NUM);
         empty    <= 1'b0;
         err_rls  <= 1'b0;
      end else if (clr) begin
         fv       <= '1;
         tag_vld  <= 1'b0;
         tag      <= '0;
         ptr      <= '0;
         free_cnt <= (TAG_W+1)'(TAG_NUM);
         empty    <= 1'b0;
         err_rls  <= 1'b0;
      end else begin
         fv      <= (fv & ~ld_clr) | rls_set;
         tag_vld <= ld || (tag_vld && !tag_rdy);
         if (ld) begin
            tag <= f;
            ptr <= (int'(f) == TAG_NUM-1) ? '0 : f + TAG_W'(1);
         end
         free_cnt <= cnt_nxt;
         empty    <= (cnt_nxt == '0);
         err_rls  <= rls_bad;
      end
   end

endmodule

// File: tb/tb_stl_tag_pool.sv
// ---------------------------------------------------------------------------
// tb_stl_tag_pool
// Two pools of 8 tags (TAG_W = 4, RLS_N = 4): index 0 lowest-free, index 1
// round-robin. A set-based model predicts every output each cycle; directed
// phases add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_stl_tag_pool;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clr      [2];
   logic       tag_rdy  [2];
   logic [3:0] rls_en   [2];
   logic [15:0] rls_tag [2];
   logic       tag_vld_o [2];
   logic [3:0] tag_o    [2];
   logic [4:0] fc_o     [2];
   logic       empty_o  [2];
   logic       err_o    [2];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   stl_tag_pool #(.TAG_W(4), .TAG_NUM(8), .RLS_N(4), .MODE(0)) u_low (
      .clk(clk), .rst_n(rst_n), .clr(clr[0]),
      .tag_vld(tag_vld_o[0]), .tag_rdy(tag_rdy[0]), .tag(tag_o[0]),
      .rls_en(rls_en[0]), .rls_tag(rls_tag[0]),
      .free_cnt(fc_o[0]), .empty(empty_o[0]), .err_rls(err_o[0]));

   stl_tag_pool #(.TAG_W(4), .TAG_NUM(8), .RLS_N(4), .MODE(1)) u_rr (
      .clk(clk), .rst_n(rst_n), .clr(clr[1]),
      .tag_vld(tag_vld_o[1]), .tag_rdy(tag_rdy[1]), .tag(tag_o[1]),
      .rls_en(rls_en[1]), .rls_tag(rls_tag[1]),
      .free_cnt(fc_o[1]), .empty(empty_o[1]), .err_rls(err_o[1]));

   task automatic chk(input string nm, input int k, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %0d, expected %0d at %0t", nm, k, act, exp, $time);
      end
   endtask

   function automatic int pc(input bit [7:0] v);
      int n = 0;
      for (int i = 0; i < 8; i++) n += int'(v[i]);
      return n;
   endfunction

   // ---------------- model: sets of free / outstanding tags ----------------
   bit [7:0] m_free [2];
   bit       m_vld  [2];
   int       m_tag  [2];
   int       m_ptr  [2];
   bit       m_err  [2];
   bit [7:0] sb_out [2];

   task automatic model_step(input int k);
      bit [7:0] fr;
      bit [7:0] rel;
      bit       bad;
      bit       ok;
      bit       ld;
      bit       got;
      int       t;
      int       u;
      int       f;
      int       st;
      fr  = m_free[k];
      rel = '0;
      bad = 1'b0;
      f   = 0;
      for (int p = 0; p < 4; p++) begin
         if (rls_en[k][p]) begin
            t  = int'(rls_tag[k][p*4 +: 4]);
            ok = (t < 8);
            if (ok) ok = !fr[t] && !(m_vld[k] && (t == m_tag[k]));
            for (int q = 0; q < p; q++) begin
               u = int'(rls_tag[k][q*4 +: 4]);
               if (rls_en[k][q] && (u == t)) ok = 1'b0;
            end
            if (ok) rel[t] = 1'b1;
            else    bad = 1'b1;
         end
      end
      if (m_vld[k] && tag_rdy[k]) sb_out[k][m_tag[k]] = 1'b1;
      ld = (!m_vld[k] || tag_rdy[k]) && (fr != 0);
      if (ld) begin
         st  = (k == 1) ? m_ptr[k] : 0;
         got = 1'b0;
         for (int i = 0; i < 8; i++) begin
            if (!got && fr[(st + i) % 8]) begin
               f   = (st + i) % 8;
               got = 1'b1;
            end
         end
         fr[f]    = 1'b0;
         m_tag[k] = f;
         m_ptr[k] = (f + 1) % 8;
      end
      m_vld[k]  = ld || (m_vld[k] && !tag_rdy[k]);
      m_free[k] = fr | rel;
      sb_out[k] = sb_out[k] & ~rel;
      m_err[k]  = bad;
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         for (int k = 0; k < 2; k++) begin
            if (!rst_n || clr[k]) begin
               m_free[k] = 8'hFF;
               m_vld[k]  = 1'b0;
               m_tag[k]  = 0;
               m_ptr[k]  = 0;
               m_err[k]  = 1'b0;
               sb_out[k] = '0;
            end else begin
               model_step(k);
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
               chk("vld", k, int'(tag_vld_o[k]), int'(m_vld[k]));
               if (m_vld[k]) chk("tag", k, int'(tag_o[k]), m_tag[k]);
               chk("free_cnt", k, int'(fc_o[k]), pc(m_free[k]));
               chk("empty", k, int'(empty_o[k]), int'(m_free[k] == 0));
               chk("err_rls", k, int'(err_o[k]), int'(m_err[k]));
               chk("conserve", k, int'(fc_o[k]) + pc(sb_out[k]) + int'(tag_vld_o[k]), 8);
               if (tag_vld_o[k] && tag_rdy[k])
                  chk("nodup", k, (tag_o[k] < 4'd8) ? int'(sb_out[k][tag_o[k][2:0]]) : 1, 0);
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic set_rls(input int k, input logic [3:0] en, input logic [15:0] tg);
      rls_en[k]  = en;
      rls_tag[k] = tg;
   endtask

   int exp_rr [5] = '{4, 5, 6, 7, 1};

   initial begin
      for (int k = 0; k < 2; k++) begin
         clr[k] = 1'b0; tag_rdy[k] = 1'b0; rls_en[k] = '0; rls_tag[k] = '0;
      end
      repeat (2) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk("rst_vld", k, int'(tag_vld_o[k]), 0);
         chk("rst_fc", k, int'(fc_o[k]), 8);
         chk("rst_empty", k, int'(empty_o[k]), 0);
         chk("rst_err", k, int'(err_o[k]), 0);
      end
      #1; rst_n = 1'b1; tag_rdy[0] = 1'b1; tag_rdy[1] = 1'b1;

      // back-to-back allocation of the full pool
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            chk("seq_vld", k, int'(tag_vld_o[k]), 1);
            chk("seq_tag", k, int'(tag_o[k]), i);
            chk("seq_fc", k, int'(fc_o[k]), 7 - i);
         end
      end
      chk("exh_empty", 0, int'(empty_o[0]), 1);
      @(negedge clk);
      chk("exh_vld", 0, int'(tag_vld_o[0]), 0);
      chk("exh_vld", 1, int'(tag_vld_o[1]), 0);

      // exhausted pool: return 5 (port 0) and 2 (port 1) together
      #1;
      for (int k = 0; k < 2; k++) begin
         tag_rdy[k] = 1'b0; set_rls(k, 4'b0011, 16'h0025);
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk("rls2_fc", k, int'(fc_o[k]), 2);
         chk("rls2_vld", k, int'(tag_vld_o[k]), 0);
      end
      #1; set_rls(0, 4'b0, 16'h0); set_rls(1, 4'b0, 16'h0);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk("rls2_tag", k, int'(tag_o[k]), 2);
         chk("rls2_fc2", k, int'(fc_o[k]), 1);
      end

      // round-robin: flush, take 0..3, return 1, expect 4,5,6,7 then 1
      #1; clr[1] = 1'b1;
      @(negedge clk);
      chk("clr_vld", 1, int'(tag_vld_o[1]), 0);
      chk("clr_fc", 1, int'(fc_o[1]), 8);
      #1; clr[1] = 1'b0; tag_rdy[1] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rr_tag", 1, int'(tag_o[1]), i);
      end
      #1; set_rls(1, 4'b0001, 16'h0001);
      @(negedge clk);
      chk("rr_tag", 1, int'(tag_o[1]), 3);
      chk("rr_fc", 1, int'(fc_o[1]), 5);
      #1; set_rls(1, 4'b0, 16'h0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("rr_wrap", 1, int'(tag_o[1]), exp_rr[i]);
      end
      #1; tag_rdy[1] = 1'b0;

      // illegal releases on pool 0 (holds tag 2, only tag 5 free)
      set_rls(0, 4'b0001, 16'h0005);                        // already free
      @(negedge clk); chk("ill_free_err", 0, int'(err_o[0]), 1); chk("ill_free_fc", 0, int'(fc_o[0]), 1);
      #1; set_rls(0, 4'b0, 16'h0);
      @(negedge clk); chk("ill_free_pulse", 0, int'(err_o[0]), 0);
      #1; set_rls(0, 4'b0001, 16'h0002);                    // held in output
      @(negedge clk); chk("ill_held_err", 0, int'(err_o[0]), 1); chk("ill_held_fc", 0, int'(fc_o[0]), 1);
      chk("ill_held_tag", 0, int'(tag_o[0]), 2);
      #1; set_rls(0, 4'b0, 16'h0);
      @(negedge clk); chk("ill_held_pulse", 0, int'(err_o[0]), 0);
      #1; set_rls(0, 4'b0011, 16'h0033);                    // duplicate ports
      @(negedge clk); chk("ill_dup_err", 0, int'(err_o[0]), 1); chk("ill_dup_fc", 0, int'(fc_o[0]), 2);
      #1; set_rls(0, 4'b0, 16'h0);
      @(negedge clk); chk("ill_dup_pulse", 0, int'(err_o[0]), 0);
      #1; set_rls(0, 4'b0001, 16'h0009);                    // out of range
      @(negedge clk); chk("ill_rng_err", 0, int'(err_o[0]), 1); chk("ill_rng_fc", 0, int'(fc_o[0]), 2);
      #1; set_rls(0, 4'b0, 16'h0);
      @(negedge clk); chk("ill_rng_pulse", 0, int'(err_o[0]), 0);

      // consumer stalled while tags come back
      #1; set_rls(0, 4'b0001, 16'h0000);
      @(negedge clk); chk("stall_fc", 0, int'(fc_o[0]), 3); chk("stall_tag", 0, int'(tag_o[0]), 2);
      #1; set_rls(0, 4'b0011, 16'h0041);
      @(negedge clk); chk("stall_fc2", 0, int'(fc_o[0]), 5); chk("stall_tag2", 0, int'(tag_o[0]), 2);
      chk("stall_err", 0, int'(err_o[0]), 0);
      #1; clr[0] = 1'b1; set_rls(0, 4'b0001, 16'h0006);    // flush beats release
      @(negedge clk); chk("clrrls_fc", 0, int'(fc_o[0]), 8); chk("clrrls_vld", 0, int'(tag_vld_o[0]), 0);
      chk("clrrls_err", 0, int'(err_o[0]), 0);
      #1; clr[0] = 1'b0; set_rls(0, 4'b0, 16'h0);
      @(negedge clk); chk("clrrls_fc2", 0, int'(fc_o[0]), 7); chk("clrrls_tag", 0, int'(tag_o[0]), 0);
      chk("clrrls_vld2", 0, int'(tag_vld_o[0]), 1);

      // random traffic on both pools
      for (int c = 0; c < 10000; c++) begin
         #1;
         for (int k = 0; k < 2; k++) begin
            logic [3:0]  en;
            logic [15:0] tg;
            int          r;
            tag_rdy[k] = ($urandom_range(0, 3) != 0);
            clr[k]     = ($urandom_range(0, 399) == 0);
            en = '0;
            tg = '0;
            for (int p = 0; p < 4; p++) begin
               en[p] = ($urandom_range(0, 2) == 0);
               r = $urandom_range(0, 7);
               if (sb_out[k][r] && ($urandom_range(0, 9) != 0)) tg[p*4 +: 4] = 4'(r);
               else                                             tg[p*4 +: 4] = 4'($urandom_range(0, 9));
            end
            set_rls(k, en, tg);
         end
         @(negedge clk);
      end

      // asynchronous reset in mid-cycle discards everything
      #1;
      for (int k = 0; k < 2; k++) begin
         clr[k] = 1'b0; tag_rdy[k] = 1'b0; set_rls(k, 4'b0, 16'h0);
      end
      #2; rst_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("arst_vld", k, int'(tag_vld_o[k]), 0);
         chk("arst_fc", k, int'(fc_o[k]), 8);
      end
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
